decode_issue_scheduler: RTL and testbench

- In-order issue controller placed after the second decode stage (mux).
- Buffers muxed decoded instructions in a small FIFO and tracks GPR busy state in a scoreboard.
- Issues the head instruction to its functional unit once there are no RAW/WAW hazards and the target unit is ready.
- Back-pressures decode with a registered stall that leaves one-entry skid margin.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_issue_scheduler_gpr_scoreboard.sv | 43 ++++
 rtl/decode_issue_scheduler.sv | 167 ++++++++++++++++
 tb/tb_decode_issue_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-side constants: functional unit codes, reg-use bits, format
// encodings and the field layout of the opaque decode payload.
package decode_pkg;

    localparam int REG_W     = 5;
    localparam int PAYLOAD_W = 128;
    localparam int FU_W      = 3;
    localparam int NUM_FU    = 8;

    localparam logic [FU_W-1:0] FU_ALU    = 3'd0;
    localparam logic [FU_W-1:0] FU_MUL    = 3'd1;
    localparam logic [FU_W-1:0] FU_DIV    = 3'd2;
    localparam logic [FU_W-1:0] FU_LSU    = 3'd3;
    localparam logic [FU_W-1:0] FU_BRANCH = 3'd4;
    localparam logic [FU_W-1:0] FU_FPU    = 3'd5;
    localparam logic [FU_W-1:0] FU_SYS    = 3'd6;
    localparam logic [FU_W-1:0] FU_SPARE  = 3'd7;

    localparam int USE_READ  = 0;
    localparam int USE_WRITE = 1;

    typedef enum logic [3:0] {
        FMT_R = 4'd0,
        FMT_I = 4'd1,
        FMT_S = 4'd2,
        FMT_B = 4'd3,
        FMT_U = 4'd4,
        FMT_J = 4'd5
    } format_e;

    // Payload layout, LSB first; the scheduler never looks inside it.
    localparam int IMM_LSB     = 0;
    localparam int IMM_W       = 32;
    localparam int OPCODE_LSB  = 32;
    localparam int OPCODE_W    = 8;
    localparam int XOPCODE_LSB = 40;
    localparam int XOPCODE_W   = 8;
    localparam int BITS_LSB    = 48;
    localparam int BITS_W      = 32;
    localparam int FORMAT_LSB  = 80;
    localparam int FORMAT_W    = 4;
    localparam int ADDR_LSB    = 84;
    localparam int ADDR_W      = 44;

    function automatic format_e payload_format(input logic [PAYLOAD_W-1:0] payload);
        return format_e'(payload[FORMAT_LSB +: FORMAT_W]);
    endfunction

endpackage

// File: rtl/decode_issue_scheduler_gpr_scoreboard.sv
// GPR busy scoreboard: issue sets busy bits, writeback clears one, and the
// head's read/write masks are checked against the registered state.
module gpr_scoreboard #(
    parameter int regWidth = 5
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [(1<<regWidth)-1:0] set_mask_i,
    input  logic                     clr_valid_i,
    input  logic [regWidth-1:0]      clr_idx_i,
    input  logic [(1<<regWidth)-1:0] rd_mask_i,
    input  logic [(1<<regWidth)-1:0] wr_mask_i,
    output logic [(1<<regWidth)-1:0] busy_o,
    output logic                     hazard_o
);
    localparam int NR = 1 << regWidth;

    logic [NR-1:0] busy_q, busy_d, clr_mask;
    logic          raw, waw;

    always_comb begin
        clr_mask = '0;
        if (clr_valid_i) begin
            clr_mask[clr_idx_i] = 1'b1;
        end
        // Set is applied after clear so a same-edge issue keeps the bit busy.
        busy_d = (busy_q & ~clr_mask) | set_mask_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign raw      = |(busy_q & rd_mask_i);
    assign waw      = |(busy_q & wr_mask_i);
    assign hazard_o = raw | waw;
    assign busy_o   = busy_q;

endmodule

// File: rtl/decode_issue_scheduler.sv
// In-order issue stage: FIFO of decoded instructions, scoreboard hazard check
// on the head, registered issue outputs and a registered decode stall.
module decode_issue_scheduler
    import decode_pkg::*;
#(
    parameter int regWidth     = REG_W,
    parameter int payloadWidth = PAYLOAD_W,
    parameter int fifoDepth    = 4,
    parameter int numFu        = NUM_FU
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [payloadWidth-1:0]  payload_i,
    input  logic [regWidth-1:0]      reg1_i,
    input  logic [regWidth-1:0]      reg2_i,
    input  logic [regWidth-1:0]      reg3_i,
    input  logic [1:0]               reg1Use_i,
    input  logic [1:0]               reg2Use_i,
    input  logic [1:0]               reg3Use_i,
    input  logic                     reg1Enable_i,
    input  logic                     reg2Enable_i,
    input  logic                     reg3Enable_i,
    input  logic                     reg3IsImmediate_i,
    input  logic [FU_W-1:0]          functionalUnitCode_i,
    input  logic [numFu-1:0]         fuReady_i,
    input  logic                     wbValid_i,
    input  logic [regWidth-1:0]      wbReg_i,
    output logic                     stall_o,
    output logic                     overflow_o,
    output logic                     issueValid_o,
    output logic [payloadWidth-1:0]  issuePayload_o,
    output logic [regWidth-1:0]      issueReg1_o,
    output logic [regWidth-1:0]      issueReg2_o,
    output logic [regWidth-1:0]      issueReg3_o,
    output logic [FU_W-1:0]          issueFu_o,
    output logic [(1<<regWidth)-1:0] busyVector_o
);
    localparam int NR = 1 << regWidth;
    localparam int PW = $clog2(fifoDepth);
    localparam int CW = PW + 1;

    logic [payloadWidth-1:0] pay_q [fifoDepth];
    logic [regWidth-1:0]     r1_q  [fifoDepth];
    logic [regWidth-1:0]     r2_q  [fifoDepth];
    logic [regWidth-1:0]     r3_q  [fifoDepth];
    logic [FU_W-1:0]         fu_q  [fifoDepth];
    logic [NR-1:0]           rdm_q [fifoDepth];
    logic [NR-1:0]           wrm_q [fifoDepth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d, overflow_q, overflow_d;
    logic          head_valid, full, pop, push, drop, hazard;
    logic [NR-1:0] rd_mask_in, wr_mask_in, set_mask;

    logic                    issue_valid_q;
    logic [payloadWidth-1:0] issue_payload_q;
    logic [regWidth-1:0]     issue_reg1_q, issue_reg2_q, issue_reg3_q;
    logic [FU_W-1:0]         issue_fu_q;

    logic op1_rd, op1_wr, op2_rd, op2_wr, op3_rd, op3_wr;

    assign op1_rd = reg1Enable_i && reg1Use_i[USE_READ];
    assign op1_wr = reg1Enable_i && reg1Use_i[USE_WRITE];
    assign op2_rd = reg2Enable_i && reg2Use_i[USE_READ];
    assign op2_wr = reg2Enable_i && reg2Use_i[USE_WRITE];
    assign op3_rd = reg3Enable_i && !reg3IsImmediate_i && reg3Use_i[USE_READ];
    assign op3_wr = reg3Enable_i && !reg3IsImmediate_i && reg3Use_i[USE_WRITE];

    for (genvar gi = 0; gi < NR; gi++) begin : g_mask
        assign rd_mask_in[gi] = (op1_rd && reg1_i == regWidth'(gi)) ||
                                (op2_rd && reg2_i == regWidth'(gi)) ||
                                (op3_rd && reg3_i == regWidth'(gi));
        assign wr_mask_in[gi] = (op1_wr && reg1_i == regWidth'(gi)) ||
                                (op2_wr && reg2_i == regWidth'(gi)) ||
                                (op3_wr && reg3_i == regWidth'(gi));
    end

    assign head_valid = (count_q != '0);
    assign full       = (count_q == CW'(fifoDepth));
    assign pop        = head_valid && !hazard && fuReady_i[fu_q[rd_ptr_q]];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = enable_i && (!full || pop);
    assign drop       = enable_i && full && !pop;
    assign set_mask   = pop ? wrm_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        stall_d    = (count_d >= CW'(fifoDepth - 1));
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            pay_q[wr_ptr_q] <= payload_i;
            r1_q[wr_ptr_q]  <= reg1_i;
            r2_q[wr_ptr_q]  <= reg2_i;
            r3_q[wr_ptr_q]  <= reg3_i;
            fu_q[wr_ptr_q]  <= functionalUnitCode_i;
            rdm_q[wr_ptr_q] <= rd_mask_in;
            wrm_q[wr_ptr_q] <= wr_mask_in;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            issue_valid_q   <= 1'b0;
            issue_payload_q <= '0;
            issue_reg1_q    <= '0;
            issue_reg2_q    <= '0;
            issue_reg3_q    <= '0;
            issue_fu_q      <= '0;
        end else begin
            issue_valid_q <= pop;
            if (pop) begin
                issue_payload_q <= pay_q[rd_ptr_q];
                issue_reg1_q    <= r1_q[rd_ptr_q];
                issue_reg2_q    <= r2_q[rd_ptr_q];
                issue_reg3_q    <= r3_q[rd_ptr_q];
                issue_fu_q      <= fu_q[rd_ptr_q];
            end
        end
    end

    gpr_scoreboard #(
        .regWidth (regWidth)
    ) u_scoreboard (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .set_mask_i  (set_mask),
        .clr_valid_i (wbValid_i),
        .clr_idx_i   (wbReg_i),
        .rd_mask_i   (rdm_q[rd_ptr_q]),
        .wr_mask_i   (wrm_q[rd_ptr_q]),
        .busy_o      (busyVector_o),
        .hazard_o    (hazard)
    );

    assign stall_o        = stall_q;
    assign overflow_o     = overflow_q;
    assign issueValid_o   = issue_valid_q;
    assign issuePayload_o = issue_payload_q;
    assign issueReg1_o    = issue_reg1_q;
    assign issueReg2_o    = issue_reg2_q;
    assign issueReg3_o    = issue_reg3_q;
    assign issueFu_o      = issue_fu_q;

endmodule

// File: tb/tb_decode_issue_scheduler.sv
// Directed bench for decode_issue_scheduler: hand-computed expectations
// checked with immediate assertions after each clock edge.
module tb_decode_issue_scheduler;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         enable_i;
    logic [127:0] payload_i;
    logic [4:0]   reg1_i, reg2_i, reg3_i;
    logic [1:0]   reg1Use_i, reg2Use_i, reg3Use_i;
    logic         reg1Enable_i, reg2Enable_i, reg3Enable_i;
    logic         reg3IsImmediate_i;
    logic [2:0]   functionalUnitCode_i;
    logic [7:0]   fuReady_i;
    logic         wbValid_i;
    logic [4:0]   wbReg_i;
    logic         stall_o, overflow_o, issueValid_o;
    logic [127:0] issuePayload_o;
    logic [4:0]   issueReg1_o, issueReg2_o, issueReg3_o;
    logic [2:0]   issueFu_o;
    logic [31:0]  busyVector_o;

    int passed = 0;
    int total  = 0;

    always #5 clock_i = ~clock_i;

    decode_issue_scheduler dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .payload_i            (payload_i),
        .reg1_i               (reg1_i),
        .reg2_i               (reg2_i),
        .reg3_i               (reg3_i),
        .reg1Use_i            (reg1Use_i),
        .reg2Use_i            (reg2Use_i),
        .reg3Use_i            (reg3Use_i),
        .reg1Enable_i         (reg1Enable_i),
        .reg2Enable_i         (reg2Enable_i),
        .reg3Enable_i         (reg3Enable_i),
        .reg3IsImmediate_i    (reg3IsImmediate_i),
        .functionalUnitCode_i (functionalUnitCode_i),
        .fuReady_i            (fuReady_i),
        .wbValid_i            (wbValid_i),
        .wbReg_i              (wbReg_i),
        .stall_o              (stall_o),
        .overflow_o           (overflow_o),
        .issueValid_o         (issueValid_o),
        .issuePayload_o       (issuePayload_o),
        .issueReg1_o          (issueReg1_o),
        .issueReg2_o          (issueReg2_o),
        .issueReg3_o          (issueReg3_o),
        .issueFu_o            (issueFu_o),
        .busyVector_o         (busyVector_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push_op(input logic [127:0] pay, input logic [2:0] fu,
                           input logic [4:0] a, input logic [1:0] ua,
                           input logic [4:0] b, input logic [1:0] ub,
                           input logic [4:0] c, input logic [1:0] uc,
                           input logic imm);
        enable_i             = 1'b1;
        payload_i            = pay;
        functionalUnitCode_i = fu;
        reg1_i = a; reg1Use_i = ua; reg1Enable_i = |ua;
        reg2_i = b; reg2Use_i = ub; reg2Enable_i = |ub;
        reg3_i = c; reg3Use_i = uc; reg3Enable_i = |uc;
        reg3IsImmediate_i = imm;
    endtask

    logic [127:0] order_exp [4];

    initial begin
        reset_i = 1'b1;
        enable_i = 1'b0; payload_i = '0; functionalUnitCode_i = '0;
        reg1_i = '0; reg2_i = '0; reg3_i = '0;
        reg1Use_i = '0; reg2Use_i = '0; reg3Use_i = '0;
        reg1Enable_i = 1'b0; reg2Enable_i = 1'b0; reg3Enable_i = 1'b0;
        reg3IsImmediate_i = 1'b0; fuReady_i = '0; wbValid_i = 1'b0; wbReg_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        check("rst_stall", stall_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_valid", issueValid_o, 0);
        check("rst_busy", busyVector_o, 0);
        check("rst_payload", issuePayload_o, 0);
        check("rst_fu", issueFu_o, 0);

        // add r5 <- r3, r4 on fu 1
        fuReady_i = 8'hFF;
        push_op(128'hA1, 3'd1, 5'd3, 2'b01, 5'd4, 2'b01, 5'd5, 2'b10, 1'b0);
        tick();
        enable_i = 1'b0;
        check("add_no_fallthrough", issueValid_o, 0);
        tick();
        check("add_valid", issueValid_o, 1);
        check("add_fu", issueFu_o, 1);
        check("add_payload", issuePayload_o, 128'hA1);
        check("add_reg1", issueReg1_o, 3);
        check("add_reg2", issueReg2_o, 4);
        check("add_reg3", issueReg3_o, 5);
        check("add_busy5", busyVector_o, 32'h20);
        tick();
        check("add_strobe_one_cycle", issueValid_o, 0);

        // RAW on r5 until writeback
        push_op(128'hB2, 3'd2, 5'd5, 2'b01, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
        tick();
        enable_i = 1'b0;
        tick();
        check("raw_blocked", issueValid_o, 0);
        check("raw_fu_hold", issueFu_o, 1);
        check("raw_payload_hold", issuePayload_o, 128'hA1);
        wbValid_i = 1'b1; wbReg_i = 5'd5;
        tick();
        wbValid_i = 1'b0;
        check("wb_no_bypass", issueValid_o, 0);
        check("wb_busy_clear", busyVector_o, 0);
        tick();
        check("raw_issue_valid", issueValid_o, 1);
        check("raw_issue_payload", issuePayload_o, 128'hB2);
        check("raw_issue_fu", issueFu_o, 2);

        // fill with all units not ready
        fuReady_i = 8'h00;
        for (int i = 0; i < 4; i++) begin
            push_op(128'hC0 + 128'(i), 3'(i), 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
            tick();
            check("fill_stall", stall_o, (i >= 2) ? 1'b1 : 1'b0);
        end
        check("fill_overflow", overflow_o, 0);
        check("fill_no_issue", issueValid_o, 0);
        push_op(128'hC4, 3'd4, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
        tick();
        check("drop_overflow", overflow_o, 1);
        check("drop_stall", stall_o, 1);

        // full FIFO: enqueue plus pop in the same cycle
        push_op(128'hC5, 3'd5, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
        fuReady_i = 8'hFF;
        tick();
        enable_i = 1'b0;
        check("full_pop_valid", issueValid_o, 1);
        check("full_pop_payload", issuePayload_o, 128'hC0);
        check("full_pop_stall", stall_o, 1);
        check("full_pop_overflow_sticky", overflow_o, 1);
        order_exp[0] = 128'hC1;
        order_exp[1] = 128'hC2;
        order_exp[2] = 128'hC3;
        order_exp[3] = 128'hC5;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("order_valid", issueValid_o, 1);
            check("order_payload", issuePayload_o, order_exp[i]);
        end
        check("order_last_fu", issueFu_o, 5);
        check("drain_stall", stall_o, 0);
        tick();
        check("drain_idle", issueValid_o, 0);

        // issue sets r7 while writeback clears r7 on the same edge
        push_op(128'hD7, 3'd3, 5'd7, 2'b10, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
        tick();
        enable_i = 1'b0;
        wbValid_i = 1'b1; wbReg_i = 5'd7;
        tick();
        wbValid_i = 1'b0;
        check("setclr_valid", issueValid_o, 1);
        check("setclr_busy7", busyVector_o, 32'h80);

        // reg3 as immediate must not touch the scoreboard
        push_op(128'hE6, 3'd6, 5'd0, 2'b00, 5'd0, 2'b00, 5'd6, 2'b11, 1'b1);
        tick();
        enable_i = 1'b0;
        tick();
        check("imm_valid", issueValid_o, 1);
        check("imm_fu", issueFu_o, 6);
        check("imm_busy", busyVector_o, 32'h80);

        // reset mid-operation
        push_op(128'hF9, 3'd4, 5'd9, 2'b10, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
        tick();
        enable_i = 1'b0;
        tick();
        check("r9_busy", busyVector_o, 32'h280);
        fuReady_i = 8'h00;
        for (int i = 0; i < 3; i++) begin
            push_op(128'hF0 + 128'(i), 3'd0, 5'd0, 2'b00, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0);
            tick();
        end
        enable_i = 1'b0;
        check("pre_reset_stall", stall_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst_busy", busyVector_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_overflow", overflow_o, 0);
        check("midrst_valid", issueValid_o, 0);
        check("midrst_payload", issuePayload_o, 0);
        fuReady_i = 8'hFF;
        tick();
        tick();
        check("midrst_fifo_empty", issueValid_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
